// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: WIDTH-bit word over valid/ready, shifted out MSB first.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifndef PISO_TX_PARITY_EN
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             last_q, last_d;
  logic             final_bit;
  logic             accept;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The cycle in which the frame's final bit is on the wire; a new word may load here.
`ifdef PISO_TX_PARITY_EN
  assign final_bit = (state_q == PARITY);
`else
  assign final_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`endif

  assign load_ready = ~rst & ((state_q == IDLE) | final_bit);
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    start_d  = 1'b0;
    last_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = parallel_in;
      cnt_d    = '0;
      valid_d  = 1'b1;
      start_d  = 1'b1;
`ifdef PISO_TX_PARITY_EN
      parity_d = ^parallel_in;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == CNT_LAST) begin
`ifdef PISO_TX_PARITY_EN
            state_d = PARITY;
            shreg_d = {parity_q, {(WIDTH - 1){1'b0}}};
            last_d  = 1'b1;
`else
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
`endif
          end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
`ifndef PISO_TX_PARITY_EN
            last_d  = (cnt_q == CNT_PENULT);
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      last_q   <= last_d;
`ifdef PISO_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // The shift register MSB is the wire bit; it is cleared whenever the link goes idle.
  assign serial_out   = shreg_q[WIDTH-1];
  assign serial_valid = valid_q;
  assign busy         = valid_q;
  assign frame_start  = start_q;
  assign frame_last   = last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed, table-driven bench for piso_tx (WIDTH=16) with a shift-left loopback receiver.
module tb_piso_tx;

  localparam int W = 16;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         lv;
  logic         ready, so, sv, fs, fl, bz;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .parallel_in  (din),
    .load_valid   (lv),
    .load_ready   (ready),
    .serial_out   (so),
    .serial_valid (sv),
    .frame_start  (fs),
    .frame_last   (fl),
    .busy         (bz)
  );

  // Loopback receiver: keeps the first W bits of each frame, remembers the frame_last bit.
  logic [W-1:0] rx;
  logic [5:0]   rx_n;
  logic         rx_last;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rx      <= '0;
      rx_n    <= '0;
      rx_last <= 1'b0;
    end else if (sv) begin
      if (fs || rx_n < W) rx <= {rx[W-2:0], so};
      rx_n <= fs ? 6'd1 : rx_n + 6'd1;
      if (fl) rx_last <= so;
    end
  end

  typedef struct {
    logic         lv;
    logic [W-1:0] din;
    logic         rdy, so, sv, fs, fl, bz;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic l, input logic [W-1:0] d, input logic r, input logic o,
                      input logic v, input logic s, input logic e, input logic b);
    vec_t x;
    x.lv = l; x.din = d; x.rdy = r; x.so = o; x.sv = v; x.fs = s; x.fl = e; x.bz = b;
    vq.push_back(x);
  endtask

  task automatic push_idle(input logic l, input logic [W-1:0] d);
    push(l, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected bits of one frame; load_valid rises at bit lv_from, din switches at bit sw.
  task automatic add_frame(input logic [W-1:0] word, input int nbits, input int lv_from,
                           input logic [W-1:0] din_a, input logic [W-1:0] din_b, input int sw);
    for (int i = 0; i < nbits; i++) begin
      logic o;
      o = (i < W) ? word[W-1-i] : ^word;
      push(i >= lv_from, (i < sw) ? din_a : din_b, i == FL - 1, o, 1'b1, i == 0, i == FL - 1,
           1'b1);
    end
  endtask

  // Each record: drive inputs just after a rising edge, compare on the falling edge.
  task automatic run_table(input string tag);
    int k;
    vec_t v;
    k = 0;
    while (vq.size() > 0) begin
      v   = vq.pop_front();
      lv  = v.lv;
      din = v.din;
      @(negedge clk);
      check($sformatf("%s[%0d].load_ready", tag, k), ready, v.rdy);
      check($sformatf("%s[%0d].serial_out", tag, k), so, v.so);
      check($sformatf("%s[%0d].serial_valid", tag, k), sv, v.sv);
      check($sformatf("%s[%0d].frame_start", tag, k), fs, v.fs);
      check($sformatf("%s[%0d].frame_last", tag, k), fl, v.fl);
      check($sformatf("%s[%0d].busy", tag, k), bz, v.bz);
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    din = '0;
    #2;
    lv  = 1'b1;
    din = 16'hFFFF;
    #1;
    check("reset.load_ready", ready, 1'b0);
    check("reset.outputs", {so, sv, fs, fl, bz}, 5'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lv  = 1'b0;
    #1;
    check("post_reset.load_ready", ready, 1'b1);

    // Single word
    push_idle(1'b0, '0);
    push_idle(1'b1, 16'hA5C3);
    add_frame(16'hA5C3, FL, FL, '0, '0, 0);
    run_table("single");
    check("loopback.word", rx, 16'hA5C3);
`ifdef PISO_TX_PARITY_EN
    check("loopback.parity", rx_last, 1'b0);
`endif
    push_idle(1'b0, '0);
    push_idle(1'b0, '0);
    run_table("idle");

    // Back-to-back with load_valid held
    push_idle(1'b1, 16'hFFFF);
    add_frame(16'hFFFF, FL, 0, 16'h0001, 16'h0001, 0);
    add_frame(16'h0001, FL, FL, '0, '0, 0);
    push_idle(1'b0, '0);
    run_table("b2b");
    check("b2b.loopback", rx, 16'h0001);

    // Backpressure: valid from bit 5, data changing while not ready
    push_idle(1'b1, 16'h5A5A);
    add_frame(16'h5A5A, FL, 5, 16'hDEAD, 16'h1234, 10);
    add_frame(16'h1234, FL, FL, '0, '0, 0);
    push_idle(1'b0, '0);
    run_table("bp");
    check("bp.loopback", rx, 16'h1234);

    // Reset mid-frame at bit 7 of 0xBEEF
    push_idle(1'b1, 16'hBEEF);
    add_frame(16'hBEEF, 7, FL, '0, '0, 0);
    run_table("abort_pre");
    lv = 1'b0;
    #1;
    check("abort.bit7_valid", sv, 1'b1);
    check("abort.bit7_value", so, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("abort.async_outputs", {so, sv, fs, fl, bz}, 5'b0);
    check("abort.load_ready", ready, 1'b0);
    @(posedge clk);
    #1;
    check("abort.held_outputs", {so, sv, fs, fl, bz}, 5'b0);
    rst = 1'b0;
    push_idle(1'b0, '0);
    push_idle(1'b0, '0);
    push_idle(1'b1, 16'h8001);
    add_frame(16'h8001, FL, FL, '0, '0, 0);
    push_idle(1'b0, '0);
    run_table("after_abort");
    check("after_abort.loopback", rx, 16'h8001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
